// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and state encoding
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period down-counter, tick on the last cycle of each bit
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic tick_o
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter parks at zero, so with CLKS_PER_BIT=1 every cycle is a tick.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-bit UART transmitter with valid/ready byte input
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]           bit_idx_q;
    logic                 stop_idx_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 tx_ready_q;

    logic                 accept;
    logic                 tick;
    logic                 load;
    logic                 bit_last;
    logic                 stop_last;
    logic                 next_bit;
    logic [DATA_BITS-1:0] shift_next;

    assign accept     = tx_valid && tx_ready_q;
    assign bit_last   = (bit_idx_q == 3'(DATA_BITS - 1));
    assign stop_last  = (stop_idx_q == 1'(STOP_BITS - 1));
    assign next_bit   = (MSB_FIRST != 0) ? shift_q[DATA_BITS-1] : shift_q[0];
    assign shift_next = (MSB_FIRST != 0) ? {shift_q[DATA_BITS-2:0], 1'b0}
                                         : {1'b0, shift_q[DATA_BITS-1:1]};

    // Reload at every bit boundary except the one that ends the frame, so the counter idles at zero.
    assign load = accept || (tick && (state_q != IDLE) && !((state_q == STOP) && stop_last));

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .rst   (rst),
        .load_i(load),
        .tick_o(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_ready_q <= 1'b1;
                    if (accept) begin
                        state_q    <= START;
                        shift_q    <= tx_data;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        tx_ready_q <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        state_q   <= DATA;
                        tx_q      <= next_bit;
                        shift_q   <= shift_next;
                        bit_idx_q <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_last) begin
                            state_q    <= STOP;
                            tx_q       <= 1'b1;
                            stop_idx_q <= 1'b0;
                        end else begin
                            tx_q      <= next_bit;
                            shift_q   <= shift_next;
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (stop_last) begin
                            state_q    <= IDLE;
                            busy_q     <= 1'b0;
                            tx_ready_q <= 1'b1;
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign tx_ready = tx_ready_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1, meaning clk cycles per serial bit; legal range 1..65535.
REQ-002 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-003 SHALL have parameter MSB_FIRST, default 1, meaning 1 = bit 7 sent first, 0 = bit 0 sent first.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 tx_data  input  8  byte to transmit, sampled only on acceptance.
REQ-007 tx_valid  input  1  upstream offers tx_data.
REQ-008 tx_ready  output  1  block can accept a byte this cycle.
REQ-009 tx  output  1  serial line, idle high, feeds the downstream UART receiver's rx.
REQ-010 busy  output  1  frame in progress (any state other than IDLE).

Function
REQ-011 States SHALL be IDLE, START, DATA, STOP.
REQ-012 Acceptance SHALL occur on a rising edge with tx_valid=1 and tx_ready=1; tx_data latched into an internal shift register at that edge.
REQ-013 tx_ready SHALL be 1 only in IDLE; tx_valid outside IDLE SHALL be ignored, and upstream must hold it.
REQ-014 IDLE -> START on acceptance; tx SHALL go low on the same edge, so latency from acceptance edge to start bit is 0 cycles.
REQ-015 Each bit (start, each data bit, each stop bit) SHALL drive tx for exactly CLKS_PER_BIT cycles, timed by a bit-period counter reloaded at each bit boundary.
REQ-016 START -> DATA after CLKS_PER_BIT cycles; DATA SHALL emit 8 bits in MSB_FIRST order, tracked by a 3-bit index that ends at 7.
REQ-017 DATA -> STOP after the 8th bit; STOP SHALL drive tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then -> IDLE.
REQ-018 Frame length SHALL be (9+STOP_BITS)*CLKS_PER_BIT cycles; back-to-back bytes SHALL have a minimum of one idle cycle (tx=1) between frames, because tx_ready returns high one cycle after STOP ends.
REQ-019 Changes on tx_data after acceptance SHALL NOT affect the frame in flight.
REQ-020 tx SHALL be registered, free of glitches, and never X after reset.
REQ-021 With CLKS_PER_BIT=1 and MSB_FIRST=1, the output SHALL match the downstream receiver exactly: one low start cycle, then 8 data cycles MSB first, so the received byte equals the sent byte.
REQ-022 The bit counter width SHALL be $clog2(CLKS_PER_BIT+1); CLKS_PER_BIT=1 SHALL need no counter wrap special-casing.

Reset
REQ-023 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, tx=1, busy=0, tx_ready=0, counters=0 and the shift register=0.
REQ-024 tx_ready SHALL rise on the first clk edge after rst deasserts.
REQ-025 rst during a frame SHALL abort it: tx returns high at once, no partial bits resume, and the byte is lost.

Structure
REQ-026 A shared package uart_pkg SHALL hold the state enum (IDLE/START/DATA/STOP) and the constant DATA_BITS=8, for reuse by the receiver.
REQ-027 One sub-module uart_baud_tick SHALL be used: a parameterised down-counter with a load input and a tick output, asserted on the last cycle of each bit period.
REQ-028 Target size: 120-250 lines of RTL in total.

Verification
REQ-029 CLKS_PER_BIT=1, MSB_FIRST=1, send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1; downstream receiver rdy=1 with data=0xA5.
REQ-030 CLKS_PER_BIT=4, MSB_FIRST=0, send 0x01 -> start low 4 cycles, bit0 high 4 cycles, 7 bits low for 28 cycles, stop high 4 cycles; busy high for 40 cycles.
REQ-031 tx_valid held high with 0x55 then 0xAA -> two frames, tx_ready high for exactly 1 cycle between them, both bytes received in order.
REQ-032 Assert rst at cycle 5 of a CLKS_PER_BIT=4 frame -> tx=1 and busy=0 before the next clk edge, tx_ready=1 one edge after release, and a new 0x3C sends correctly.
REQ-033 Change tx_data from 0x0F to 0xF0 one cycle after acceptance -> the line carries 0x0F.
REQ-034 STOP_BITS=2, CLKS_PER_BIT=2 -> stop high for 4 cycles, frame length 22 cycles.
